wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback stage directly upstream of the register file. Accepts completed results from two producers (ALU and load unit) over valid/ready handshakes, arbitrates one write per cycle, and drives the register file's `write`/`writeReg`/`writeData` inputs from registered outputs. Also keeps a 31-bit pending-write scoreboard so decode can stall on read-after-write hazards that the register file's same-cycle bypass cannot cover.

## Interface
- `DATAWIDTH`, 32, result/data width; must match the register file.
- `STARVE_LIMIT`, 4, consecutive lost ALU arbitrations before the ALU is forced to win; legal range 1..15.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; **one clock; reset is synchronous and active-high**.
- `issue_valid`  in  1  decode issued an instruction that will write `issue_reg`.
- `issue_reg`  in  5  destination reserved at issue.
- `alu_valid`  in  1  ALU result available.
- `alu_reg`  in  5  ALU destination.
- `alu_data`  in  DATAWIDTH  ALU result.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `mem_valid`  in  1  load result available.
- `mem_reg`  in  5  load destination.
- `mem_data`  in  DATAWIDTH  load data.
- `mem_ready`  out  1  load result accepted this cycle.
- `readReg1`, `readReg2`  in  5 each  decode's source registers (same nets feeding the register file).
- `write`  out  1  register-file write enable.
- `writeReg`  out  5  register-file write address.
- `writeData`  out  DATAWIDTH  register-file write data.
- `hazard`  out  1  decode must stall this cycle.

## Operation
- Transfer occurs on a source when its valid and ready are both high at a rising edge. Producers hold reg/data stable while valid is high and not accepted.
- Arbitration (combinational grant, at most one ready high per cycle, both low while `rst`):
  - Only one valid: that source is granted.
  - Both valid: mem wins, unless starve counter == STARVE_LIMIT, then ALU wins.
- Starve counter (4 bits): increments when `alu_valid` is high and ALU is not granted; clears when ALU is granted or `alu_valid` is low; saturates at STARVE_LIMIT.
- Accepted result is registered: next cycle `write`=1 (unless dest is 0), `writeReg`/`writeData` = accepted reg/data. With no transfer, `write`=0 next cycle; `writeReg`/`writeData` keep their last values.
- Destination 0: accepted normally (ready high), `write` stays 0, scoreboard untouched.
- Scoreboard `busy[31:1]`, bit 0 hardwired 0:
  - Set at edge when `issue_valid` and `issue_reg`!=0.
  - Cleared at edge when `write`=1 for `writeReg`.
  - Set and clear of the same register at the same edge: set wins.
- `hazard` = OR over n∈{1,2} of (`busy[readRegN]` and not (`write` and `writeReg`==`readRegN`)). The register-file bypass covers the same-cycle write, so that case is not a hazard.

## Timing
- Reset values: `write`=0, `writeReg`=0, `writeData`=0, `busy`=0, starve counter=0, `hazard`=0; ready outputs 0 while `rst` is high.
- Acceptance to `write` asserted: 1 cycle. Issue to busy visible on `hazard`: 1 cycle.
- Throughput: one result per cycle; back-to-back grants produce consecutive `write` pulses.
- Reset mid-operation: a registered but not yet committed write is dropped (`write`=0 after the reset edge); the scoreboard is cleared.
- Simultaneous issue and writeback to the same reg: bit stays busy; `hazard` is low in the commit cycle (bypass), then high from the next cycle.

## Structure
- Shared package: `NUM_REGS`=32, `REGADDR_W`=5, `REG_ZERO`=5'd0, and a source-select enum {SRC_NONE, SRC_ALU, SRC_MEM}.
- One sub-module: `wb_scoreboard` (busy vector, set/clear priority, hazard lookup with bypass mask). Arbiter, starve counter and output registers stay in the top module.

## Test plan
- Single ALU result reg 5, data 0xDEADBEEF → `alu_ready` high that cycle; next cycle `write`=1, `writeReg`=5, `writeData`=0xDEADBEEF; following cycle `write`=0.
- Both sources valid continuously (ALU reg 3, mem reg 4), STARVE_LIMIT=4 → grants mem,mem,mem,mem,ALU, then the pattern repeats; no cycle with both readys high.
- Issue reg 7, then `readReg1`=7 → `hazard`=1 from the cycle after issue; in the commit cycle (`write`=1, `writeReg`=7) `hazard`=0; busy[7] cleared afterwards.
- Mem result to reg 0, data 0x1234 → `mem_ready`=1, `write` stays 0, `hazard` never asserted for `readReg2`=0.
- Issue reg 9 in the same cycle as the commit of reg 9 → busy[9] remains 1; `hazard`=1 the following cycle with `readReg2`=9.
- Assert `rst` one cycle after accepting ALU reg 12 → `write`=0, busy all clear, both readys low during reset.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter and its scoreboard.
package wb_arbiter_pkg;

  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned REGADDR_W = 5;
  localparam logic [REGADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_MEM
  } src_sel_e;

  // One-hot register mask; x0 never appears because it is not trackable.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REGADDR_W-1:0] r);
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer handshakes, decode lookup and register-file write port of the writeback stage.
interface wb_arbiter_if #(
  parameter int unsigned DATAWIDTH = 32
) ();
  import wb_arbiter_pkg::*;

  logic                 issue_valid;
  logic [REGADDR_W-1:0] issue_reg;

  logic                 alu_valid;
  logic [REGADDR_W-1:0] alu_reg;
  logic [DATAWIDTH-1:0] alu_data;
  logic                 alu_ready;

  logic                 mem_valid;
  logic [REGADDR_W-1:0] mem_reg;
  logic [DATAWIDTH-1:0] mem_data;
  logic                 mem_ready;

  logic [REGADDR_W-1:0] readReg1;
  logic [REGADDR_W-1:0] readReg2;

  logic                 write;
  logic [REGADDR_W-1:0] writeReg;
  logic [DATAWIDTH-1:0] writeData;
  logic                 hazard;

  modport master (
    output issue_valid, issue_reg,
    output alu_valid, alu_reg, alu_data,
    output mem_valid, mem_reg, mem_data,
    output readReg1, readReg2,
    input  alu_ready, mem_ready,
    input  write, writeReg, writeData, hazard
  );

  modport slave (
    input  issue_valid, issue_reg,
    input  alu_valid, alu_reg, alu_data,
    input  mem_valid, mem_reg, mem_data,
    input  readReg1, readReg2,
    output alu_ready, mem_ready,
    output write, writeReg, writeData, hazard
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for x1..x31 with same-cycle register-file bypass masking.
module wb_scoreboard
  import wb_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_valid,
  input  logic [REGADDR_W-1:0] set_reg,
  input  logic                 clr_valid,
  input  logic [REGADDR_W-1:0] clr_reg,
  input  logic [REGADDR_W-1:0] rd_reg_a,
  input  logic [REGADDR_W-1:0] rd_reg_b,
  output logic                 hazard
);

  logic [NUM_REGS-1:1] busy_q;
  logic [NUM_REGS-1:0] busy_full;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] busy_d;
  logic                hit_a;
  logic                hit_b;

  assign busy_full = {busy_q, 1'b0};

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_valid) begin
      set_mask = reg_onehot(set_reg);
    end
    if (clr_valid) begin
      clr_mask = reg_onehot(clr_reg);
    end
    // Set is applied after clear so a same-edge reissue keeps the register busy.
    busy_d = (busy_full & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d[NUM_REGS-1:1];
    end
  end

  // The register file forwards the write in flight, so that register is not a hazard.
  always_comb begin
    hit_a  = busy_full[rd_reg_a] && !(clr_valid && (clr_reg == rd_reg_a));
    hit_b  = busy_full[rd_reg_b] && !(clr_valid && (clr_reg == rd_reg_b));
    hazard = hit_a || hit_b;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants ALU or load results one per cycle with ALU starvation guard,
// registers the register-file write and tracks pending destinations for decode stalls.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DATAWIDTH    = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  src_sel_e             grant;
  logic [3:0]           starve_q;
  logic [3:0]           starve_d;

  logic                 write_q;
  logic                 write_d;
  logic [REGADDR_W-1:0] write_reg_q;
  logic [REGADDR_W-1:0] write_reg_d;
  logic [DATAWIDTH-1:0] write_data_q;
  logic [DATAWIDTH-1:0] write_data_d;
  logic                 hazard;

  // Loads normally win; a starved ALU gets one forced grant.
  always_comb begin
    grant = SRC_NONE;
    if (!rst) begin
      if (bus.alu_valid && bus.mem_valid) begin
        grant = (starve_q == StarveMax) ? SRC_ALU : SRC_MEM;
      end else if (bus.alu_valid) begin
        grant = SRC_ALU;
      end else if (bus.mem_valid) begin
        grant = SRC_MEM;
      end
    end
  end

  assign bus.alu_ready = (grant == SRC_ALU);
  assign bus.mem_ready = (grant == SRC_MEM);

  always_comb begin
    starve_d = '0;
    if (bus.alu_valid && (grant != SRC_ALU)) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
    end
  end

  always_comb begin
    write_d      = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    unique case (grant)
      SRC_ALU: begin
        write_d      = (bus.alu_reg != REG_ZERO);
        write_reg_d  = bus.alu_reg;
        write_data_d = bus.alu_data;
      end
      SRC_MEM: begin
        write_d      = (bus.mem_reg != REG_ZERO);
        write_reg_d  = bus.mem_reg;
        write_data_d = bus.mem_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q     <= '0;
      write_q      <= 1'b0;
      write_reg_q  <= REG_ZERO;
      write_data_q <= '0;
    end else begin
      starve_q     <= starve_d;
      write_q      <= write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign bus.write     = write_q;
  assign bus.writeReg  = write_reg_q;
  assign bus.writeData = write_data_q;

  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (bus.issue_valid),
    .set_reg   (bus.issue_reg),
    .clr_valid (write_q),
    .clr_reg   (write_reg_q),
    .rd_reg_a  (bus.readReg1),
    .rd_reg_b  (bus.readReg2),
    .hazard    (hazard)
  );

  assign bus.hazard = hazard;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed vector bench for wb_arbiter: arbitration, starvation, scoreboard bypass and reset.
module tb_wb_arbiter;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        iv;
    logic [4:0]  ir;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_ar;
    logic        e_mr;
    logic        e_w;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_hz;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  wb_arbiter_if #(.DATAWIDTH(32)) bus ();

  wb_arbiter #(
    .DATAWIDTH    (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic vec_t mk(
    input logic av, input logic [4:0] ar, input logic [31:0] ad,
    input logic mv, input logic [4:0] mr, input logic [31:0] md,
    input logic iv, input logic [4:0] ir, input logic [4:0] r1, input logic [4:0] r2,
    input logic e_ar, input logic e_mr, input logic e_w, input logic [4:0] e_wr,
    input logic [31:0] e_wd, input logic e_hz);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md;
    v.iv = iv; v.ir = ir; v.r1 = r1; v.r2 = r2;
    v.e_ar = e_ar; v.e_mr = e_mr; v.e_w = e_w; v.e_wr = e_wr; v.e_wd = e_wd; v.e_hz = e_hz;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.alu_valid   = v.av;
    bus.alu_reg     = v.ar;
    bus.alu_data    = v.ad;
    bus.mem_valid   = v.mv;
    bus.mem_reg     = v.mr;
    bus.mem_data    = v.md;
    bus.issue_valid = v.iv;
    bus.issue_reg   = v.ir;
    bus.readReg1    = v.r1;
    bus.readReg2    = v.r2;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    // av ar ad | mv mr md | iv ir r1 r2 || alu_rdy mem_rdy write wreg wdata hazard
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0, 31, 1, 0, 0, 0, 0, 0,            0));
    vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,      0, 0, 0,  0, 1, 0, 0, 0, 0,            0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0, 0,  0, 0, 0, 1, 5, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0, 0,  0, 0, 0, 0, 5, 32'hDEADBEEF, 0));
    // load to x0: accepted, never written, never a hazard
    vecs.push_back(mk(0, 0, 0,            1, 0, 'h1234, 0, 0, 0,  0, 0, 1, 0, 5, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0, 0,  0, 0, 0, 0, 0, 32'h1234,     0));
    // issue x7, stall, commit with bypass, then clear
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,      1, 7, 7,  0, 0, 0, 0, 0, 32'h1234,     0));
    vecs.push_back(mk(1, 7, 'h77,         0, 0, 0,      0, 0, 7,  0, 1, 0, 0, 0, 32'h1234,     1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0, 7,  0, 0, 0, 1, 7, 'h77,         0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0, 7,  0, 0, 0, 0, 7, 'h77,         0));
    // both valid: mem x4, then ALU, then mem again
    vecs.push_back(mk(1, 3, 'h33,         1, 4, 'h44,   0, 0, 0,  0, 0, 1, 0, 7, 'h77,         0));
    vecs.push_back(mk(1, 3, 'h33,         1, 4, 'h44,   0, 0, 0,  0, 0, 1, 1, 4, 'h44,         0));
    vecs.push_back(mk(1, 3, 'h33,         1, 4, 'h44,   0, 0, 0,  0, 0, 1, 1, 4, 'h44,         0));
    vecs.push_back(mk(1, 3, 'h33,         1, 4, 'h44,   0, 0, 0,  0, 0, 1, 1, 4, 'h44,         0));
    vecs.push_back(mk(1, 3, 'h33,         1, 4, 'h44,   0, 0, 0,  0, 1, 0, 1, 4, 'h44,         0));
    vecs.push_back(mk(1, 3, 'h33,         1, 4, 'h44,   0, 0, 0,  0, 0, 1, 1, 3, 'h33,         0));
    vecs.push_back(mk(1, 3, 'h33,         1, 4, 'h44,   0, 0, 0,  0, 0, 1, 1, 4, 'h44,         0));
    vecs.push_back(mk(1, 3, 'h33,         0, 0, 0,      0, 0, 0,  0, 1, 0, 1, 4, 'h44,         0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0, 0,  0, 0, 0, 1, 3, 'h33,         0));
    // reissue x9 on the edge that commits x9: stays busy
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,      1, 9, 0,  9, 0, 0, 0, 3, 'h33,         0));
    vecs.push_back(mk(1, 9, 'h99,         0, 0, 0,      0, 0, 0,  9, 1, 0, 0, 3, 'h33,         1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,      1, 9, 0,  9, 0, 0, 1, 9, 'h99,         0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0, 0,  9, 0, 0, 0, 9, 'h99,         1));
    // alu_valid dropping clears the starve count
    vecs.push_back(mk(1, 3, 'h33,         1, 4, 'h44,   0, 0, 0,  9, 0, 1, 0, 9, 'h99,         1));
    vecs.push_back(mk(1, 3, 'h33,         1, 4, 'h44,   0, 0, 0,  9, 0, 1, 1, 4, 'h44,         1));
    vecs.push_back(mk(1, 3, 'h33,         1, 4, 'h44,   0, 0, 0,  9, 0, 1, 1, 4, 'h44,         1));
    vecs.push_back(mk(0, 0, 0,            1, 4, 'h44,   0, 0, 0,  9, 0, 1, 1, 4, 'h44,         1));
    vecs.push_back(mk(1, 3, 'h33,         1, 4, 'h44,   0, 0, 0,  9, 0, 1, 1, 4, 'h44,         1));
    vecs.push_back(mk(1, 3, 'h33,         1, 4, 'h44,   0, 0, 0,  9, 0, 1, 1, 4, 'h44,         1));
    vecs.push_back(mk(1, 3, 'h33,         1, 4, 'h44,   0, 0, 0,  9, 0, 1, 1, 4, 'h44,         1));
    vecs.push_back(mk(1, 3, 'h33,         1, 4, 'h44,   0, 0, 0,  9, 0, 1, 1, 4, 'h44,         1));
    vecs.push_back(mk(1, 3, 'h33,         1, 4, 'h44,   0, 0, 0,  9, 1, 0, 1, 4, 'h44,         1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0, 0,  9, 0, 0, 1, 3, 'h33,         1));

    // Reset with both producers valid: no grants while rst is high.
    rst = 1'b1;
    drive(mk(1, 3, 'h33, 1, 4, 'h44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    check("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d_alu_ready", i), 32'(bus.alu_ready), 32'(vecs[i].e_ar));
      check($sformatf("v%0d_mem_ready", i), 32'(bus.mem_ready), 32'(vecs[i].e_mr));
      check($sformatf("v%0d_write", i), 32'(bus.write), 32'(vecs[i].e_w));
      check($sformatf("v%0d_writeReg", i), 32'(bus.writeReg), 32'(vecs[i].e_wr));
      check($sformatf("v%0d_writeData", i), bus.writeData, vecs[i].e_wd);
      check($sformatf("v%0d_hazard", i), 32'(bus.hazard), 32'(vecs[i].e_hz));
      @(posedge clk);
      #1;
    end

    // Accept ALU x12, then reset before it can matter; x9 is still busy here.
    drive(mk(1, 12, 'hC0C0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("mid_alu_ready", 32'(bus.alu_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(mk(1, 3, 'h33, 1, 4, 'h44, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("mid_rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    check("mid_rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    check("mid_rst_write", 32'(bus.write), 32'd1);
    check("mid_rst_writeReg", 32'(bus.writeReg), 32'd12);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    bus.readReg2 = 5'd9;
    @(negedge clk);
    check("post_rst_write", 32'(bus.write), 32'd0);
    check("post_rst_writeReg", 32'(bus.writeReg), 32'd0);
    check("post_rst_writeData", bus.writeData, 32'd0);
    check("post_rst_hazard", 32'(bus.hazard), 32'd0);
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
